// File: rtl/cache_bus_arb_pkg.sv
// Shared types and bus request encodings for the I$/D$ burst bus arbiter.
package cache_bus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GNT_I,
      ARB_GNT_D
   } arbstate_t;

   localparam logic [1:0] BUSRW_READ  = 2'b10;
   localparam logic [1:0] BUSRW_WRITE = 2'b01;

endpackage

// File: rtl/arb_beat_counter.sv
// Beat index within a burst; flags the final beat of the line.
module arb_beat_counter #(
   parameter int unsigned LOGBWPL = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   output logic [LOGBWPL-1:0] count,
   output logic               last
);

   logic [LOGBWPL-1:0] countQ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         countQ <= '0;
      end else if (clr) begin
         countQ <= '0;
      end else if (en) begin
         countQ <= countQ + 1'b1;
      end
   end

   assign count = countQ;
   assign last  = &countQ;

endmodule

// File: rtl/cache_bus_arb.sv
// Arbitrates the shared burst bus between I$ and D$: registered D$-priority grant,
// I$ starvation guard, and a D$ writeback/fetch chain lock.
module cache_bus_arb
   import cache_bus_arb_pkg::*;
#(
   parameter int unsigned PA_BITS      = 56,
   parameter int unsigned LOGBWPL      = 3,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         ICacheBusRW,
   input  logic [PA_BITS-1:0] ICacheBusAdr,
   input  logic               ICacheAbort,
   input  logic [1:0]         DCacheBusRW,
   input  logic [PA_BITS-1:0] DCacheBusAdr,
   input  logic               DCacheAbort,
   input  logic               BusBeatDone,
   output logic [1:0]         BusRW,
   output logic [PA_BITS-1:0] BusAdr,
   output logic               GntD,
   output logic               ICacheBusAck,
   output logic               DCacheBusAck,
   output logic [LOGBWPL-1:0] IBeatCount,
   output logic [LOGBWPL-1:0] DBeatCount
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

   arbstate_t          stateQ, stateD;
   logic [SW-1:0]      starveQ, starveD;
   logic               chainQ, chainD;
   logic [LOGBWPL-1:0] beatCnt;
   logic               beatLast, beatEn, beatClr;
   logic               reqI, reqD;

   assign reqI = (|ICacheBusRW) & ~ICacheAbort;
   assign reqD = (|DCacheBusRW) & ~DCacheAbort;

   assign beatEn  = BusBeatDone && (stateQ != ARB_IDLE);
   assign beatClr = (stateQ == ARB_IDLE);

   arb_beat_counter #(
      .LOGBWPL(LOGBWPL)
   ) u_beatCounter (
      .clk  (clk),
      .reset(reset),
      .en   (beatEn),
      .clr  (beatClr),
      .count(beatCnt),
      .last (beatLast)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ  <= ARB_IDLE;
         starveQ <= '0;
         chainQ  <= 1'b0;
      end else begin
         stateQ  <= stateD;
         starveQ <= starveD;
         chainQ  <= chainD;
      end
   end

   always_comb begin
      stateD       = stateQ;
      starveD      = starveQ;
      chainD       = chainQ;
      BusRW        = '0;
      BusAdr       = '0;
      GntD         = 1'b0;
      ICacheBusAck = 1'b0;
      DCacheBusAck = 1'b0;
      IBeatCount   = '0;
      DBeatCount   = '0;
      unique case (stateQ)
         ARB_IDLE: begin
            chainD = 1'b0;
            // Chained fetch after a writeback does not count against the I$.
            if (chainQ && reqD) begin
               stateD = ARB_GNT_D;
            end else if (reqI && (starveQ == StarveMax)) begin
               stateD  = ARB_GNT_I;
               starveD = '0;
            end else if (reqD) begin
               stateD = ARB_GNT_D;
               if (reqI) starveD = starveQ + 1'b1;
            end else if (reqI) begin
               stateD  = ARB_GNT_I;
               starveD = '0;
            end
         end
         ARB_GNT_I: begin
            BusRW      = ICacheBusRW;
            BusAdr     = ICacheBusAdr;
            IBeatCount = beatCnt;
            if (BusBeatDone && beatLast) begin
               ICacheBusAck = 1'b1;
               stateD       = ARB_IDLE;
            end else if (ICacheAbort && (beatCnt == '0) && !BusBeatDone) begin
               stateD = ARB_IDLE;
            end
         end
         ARB_GNT_D: begin
            BusRW      = DCacheBusRW;
            BusAdr     = DCacheBusAdr;
            GntD       = 1'b1;
            DBeatCount = beatCnt;
            if (BusBeatDone && beatLast) begin
               DCacheBusAck = 1'b1;
               stateD       = ARB_IDLE;
               chainD       = |(DCacheBusRW & BUSRW_WRITE);
            end else if (DCacheAbort && (beatCnt == '0) && !BusBeatDone) begin
               stateD = ARB_IDLE;
            end
         end
         default: stateD = ARB_IDLE;
      endcase
   end

   assert property (@(posedge clk) disable iff (!reset) ICacheBusRW != 2'b11);
   assert property (@(posedge clk) disable iff (!reset) DCacheBusRW != 2'b11);
   assert property (@(posedge clk) disable iff (!reset) (stateQ == ARB_IDLE) |-> !BusBeatDone);
   assert property (@(posedge clk) disable iff (!reset)
      ((stateQ == ARB_GNT_I) && ((beatCnt != '0) || BusBeatDone)) |-> (ICacheBusRW != 2'b00));
   assert property (@(posedge clk) disable iff (!reset)
      ((stateQ == ARB_GNT_D) && ((beatCnt != '0) || BusBeatDone)) |-> (DCacheBusRW != 2'b00));

endmodule

// File: tb/tb_cache_bus_arb.sv
// Directed bench for cache_bus_arb: grant order, beat counts, acks, chain, starvation, abort, reset.
module tb_cache_bus_arb;
   import cache_bus_arb_pkg::*;

   localparam int unsigned PA = 56;
   localparam int unsigned LB = 3;
   localparam int unsigned SL = 4;
   localparam int unsigned SW = $clog2(SL + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    iRW, dRW;
   logic [PA-1:0] iAdr, dAdr;
   logic          iAbort, dAbort, beatDone;
   logic [1:0]    busRW;
   logic [PA-1:0] busAdr;
   logic          gntD, iAck, dAck;
   logic [LB-1:0] iBeat, dBeat;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cache_bus_arb #(
      .PA_BITS     (PA),
      .LOGBWPL     (LB),
      .STARVE_LIMIT(SL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ICacheBusRW (iRW),
      .ICacheBusAdr(iAdr),
      .ICacheAbort (iAbort),
      .DCacheBusRW (dRW),
      .DCacheBusAdr(dAdr),
      .DCacheAbort (dAbort),
      .BusBeatDone (beatDone),
      .BusRW       (busRW),
      .BusAdr      (busAdr),
      .GntD        (gntD),
      .ICacheBusAck(iAck),
      .DCacheBusAck(dAck),
      .IBeatCount  (iBeat),
      .DBeatCount  (dBeat)
   );

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      iRW = 2'b00; dRW = 2'b00; iAdr = '0; dAdr = '0;
      iAbort = 1'b0; dAbort = 1'b0; beatDone = 1'b0;
      nxt();
      nxt();
      checks++;
      if ({busRW, busAdr, gntD, iAck, dAck, iBeat, dBeat} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got busRW=%b adr=%h gntD=%b", busRW, busAdr, gntD);
      end
      checks++;
      if (dut.starveQ !== '0 || dut.chainQ !== 1'b0) begin
         errs++;
         $display("FAIL reset_regs: got starve=%0d chain=%b want 0 0", dut.starveQ, dut.chainQ);
      end
      reset = 1'b1;
      nxt();
   endtask

   task automatic test_i_read();
      iRW = BUSRW_READ; iAdr = 56'h80001000;
      #1;
      checks++;
      if (busRW !== 2'b00) begin
         errs++; $display("FAIL iread_latency: got busRW=%b want 00", busRW);
      end
      nxt();
      checks++;
      if (busRW !== 2'b10 || busAdr !== 56'h80001000 || gntD !== 1'b0) begin
         errs++;
         $display("FAIL iread_grant: got rw=%b adr=%h gntD=%b want 10 80001000 0", busRW, busAdr, gntD);
      end
      for (int b = 0; b < 8; b++) begin
         beatDone = 1'b1;
         #1;
         checks++;
         if (iBeat !== LB'(b) || dBeat !== '0) begin
            errs++; $display("FAIL iread_beat%0d: got i=%0d d=%0d want %0d 0", b, iBeat, dBeat, b);
         end
         checks++;
         if (iAck !== (b == 7) || dAck !== 1'b0) begin
            errs++; $display("FAIL iread_ack%0d: got iAck=%b dAck=%b want %b 0", b, iAck, dAck, b == 7);
         end
         nxt();
      end
      beatDone = 1'b0; iRW = 2'b00;
      #1;
      checks++;
      if (busRW !== 2'b00 || iAck !== 1'b0 || iBeat !== '0) begin
         errs++; $display("FAIL iread_idle: got rw=%b ack=%b beat=%0d want 00 0 0", busRW, iAck, iBeat);
      end
      nxt();
   endtask

   task automatic test_both_same_cycle();
      iRW = BUSRW_READ; iAdr = 56'h1000;
      dRW = BUSRW_READ; dAdr = 56'h2000;
      nxt();
      checks++;
      if (gntD !== 1'b1 || busAdr !== 56'h2000 || dut.starveQ !== SW'(1)) begin
         errs++;
         $display("FAIL both_dwins: got gntD=%b adr=%h starve=%0d want 1 2000 1", gntD, busAdr, dut.starveQ);
      end
      for (int b = 0; b < 8; b++) begin
         beatDone = 1'b1;
         #1;
         checks++;
         if (dBeat !== LB'(b) || iBeat !== '0 || dAck !== (b == 7) || iAck !== 1'b0) begin
            errs++;
            $display("FAIL both_dbeat%0d: got d=%0d i=%0d dAck=%b iAck=%b", b, dBeat, iBeat, dAck, iAck);
         end
         nxt();
      end
      beatDone = 1'b0; dRW = 2'b00;
      #1;
      checks++;
      if (busRW !== 2'b00 || gntD !== 1'b0) begin
         errs++; $display("FAIL both_gap: got rw=%b gntD=%b want 00 0", busRW, gntD);
      end
      nxt();
      checks++;
      if (gntD !== 1'b0 || busRW !== 2'b10 || busAdr !== 56'h1000 || dut.starveQ !== '0) begin
         errs++;
         $display("FAIL both_igrant: got gntD=%b rw=%b adr=%h starve=%0d", gntD, busRW, busAdr, dut.starveQ);
      end
      for (int b = 0; b < 8; b++) begin
         beatDone = 1'b1;
         #1;
         if (b == 7) begin
            checks++;
            if (iAck !== 1'b1) begin
               errs++; $display("FAIL both_iack: got %b want 1", iAck);
            end
         end
         nxt();
      end
      beatDone = 1'b0; iRW = 2'b00;
      nxt();
   endtask

   task automatic test_chain_starve();
      dRW = BUSRW_WRITE; dAdr = 56'h3000;
      nxt();
      iRW = BUSRW_READ; iAdr = 56'h4000;
      checks++;
      if (gntD !== 1'b1 || busRW !== 2'b01 || dut.starveQ !== '0) begin
         errs++; $display("FAIL chain_wb: got gntD=%b rw=%b starve=%0d want 1 01 0", gntD, busRW, dut.starveQ);
      end
      for (int b = 0; b < 8; b++) begin
         beatDone = 1'b1;
         #1;
         if (b == 7) begin
            checks++;
            if (dAck !== 1'b1) begin
               errs++; $display("FAIL chain_wback_ack: got %b want 1", dAck);
            end
         end
         nxt();
      end
      beatDone = 1'b0; dRW = BUSRW_READ;
      nxt();
      checks++;
      if (gntD !== 1'b1 || busRW !== 2'b10 || dut.starveQ !== '0) begin
         errs++;
         $display("FAIL chain_fetch: got gntD=%b rw=%b starve=%0d want 1 10 0", gntD, busRW, dut.starveQ);
      end
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < 8; b++) begin
            beatDone = 1'b1;
            nxt();
         end
         beatDone = 1'b0;
         nxt();
         if (g < 4) begin
            checks++;
            if (gntD !== 1'b1 || dut.starveQ !== SW'(g + 1)) begin
               errs++;
               $display("FAIL starve_d%0d: got gntD=%b starve=%0d want 1 %0d", g + 1, gntD, dut.starveQ, g + 1);
            end
         end else begin
            checks++;
            if (gntD !== 1'b0 || busAdr !== 56'h4000 || iBeat !== '0 || dut.starveQ !== '0) begin
               errs++;
               $display("FAIL starve_iforced: got gntD=%b adr=%h starve=%0d want 0 4000 0", gntD, busAdr, dut.starveQ);
            end
         end
      end
      dRW = 2'b00;
      for (int b = 0; b < 8; b++) begin
         beatDone = 1'b1;
         #1;
         if (b == 7) begin
            checks++;
            if (iAck !== 1'b1) begin
               errs++; $display("FAIL starve_iack: got %b want 1", iAck);
            end
         end
         nxt();
      end
      beatDone = 1'b0; iRW = 2'b00;
      nxt();
   endtask

   task automatic test_abort();
      dRW = BUSRW_READ; dAdr = 56'h5000;
      iRW = BUSRW_READ; iAdr = 56'h6000;
      nxt();
      dAbort = 1'b1;
      #1;
      checks++;
      if (gntD !== 1'b1 || dAck !== 1'b0) begin
         errs++; $display("FAIL abort_grant: got gntD=%b dAck=%b want 1 0", gntD, dAck);
      end
      nxt();
      checks++;
      if (busRW !== 2'b00 || gntD !== 1'b0 || dAck !== 1'b0) begin
         errs++; $display("FAIL abort_idle: got rw=%b gntD=%b dAck=%b want 00 0 0", busRW, gntD, dAck);
      end
      nxt();
      dRW = 2'b00; dAbort = 1'b0;
      checks++;
      if (gntD !== 1'b0 || busRW !== 2'b10 || busAdr !== 56'h6000) begin
         errs++; $display("FAIL abort_igrant: got gntD=%b rw=%b adr=%h want 0 10 6000", gntD, busRW, busAdr);
      end
      for (int b = 0; b < 8; b++) begin
         beatDone = 1'b1;
         nxt();
      end
      beatDone = 1'b0; iRW = 2'b00;
      dRW = BUSRW_READ; dAdr = 56'h7000;
      nxt();
      for (int b = 0; b < 2; b++) begin
         beatDone = 1'b1;
         nxt();
      end
      beatDone = 1'b0; dAbort = 1'b1;
      nxt();
      checks++;
      if (gntD !== 1'b1 || dBeat !== LB'(2) || dAck !== 1'b0) begin
         errs++; $display("FAIL abort_late: got gntD=%b beat=%0d ack=%b want 1 2 0", gntD, dBeat, dAck);
      end
      for (int b = 2; b < 8; b++) begin
         beatDone = 1'b1;
         #1;
         checks++;
         if (dBeat !== LB'(b) || dAck !== (b == 7)) begin
            errs++; $display("FAIL abort_late_beat%0d: got beat=%0d ack=%b", b, dBeat, dAck);
         end
         nxt();
      end
      beatDone = 1'b0; dRW = 2'b00; dAbort = 1'b0;
      nxt();
   endtask

   task automatic test_reset_mid_burst();
      dRW = BUSRW_READ; dAdr = 56'h8000;
      nxt();
      for (int b = 0; b < 4; b++) begin
         beatDone = 1'b1;
         nxt();
      end
      beatDone = 1'b0;
      #1;
      checks++;
      if (dBeat !== LB'(4) || gntD !== 1'b1) begin
         errs++; $display("FAIL rst_pre: got beat=%0d gntD=%b want 4 1", dBeat, gntD);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({busRW, busAdr, gntD, iAck, dAck, iBeat, dBeat} !== '0) begin
         errs++; $display("FAIL rst_async: got rw=%b gntD=%b dBeat=%0d want 0", busRW, gntD, dBeat);
      end
      nxt();
      reset = 1'b1;
      nxt();
      checks++;
      if (gntD !== 1'b1 || dBeat !== '0 || busAdr !== 56'h8000) begin
         errs++; $display("FAIL rst_restart: got gntD=%b beat=%0d adr=%h want 1 0 8000", gntD, dBeat, busAdr);
      end
      for (int b = 0; b < 8; b++) begin
         beatDone = 1'b1;
         #1;
         if (b == 7) begin
            checks++;
            if (dAck !== 1'b1) begin
               errs++; $display("FAIL rst_ack: got %b want 1", dAck);
            end
         end
         nxt();
      end
      beatDone = 1'b0; dRW = 2'b00;
      nxt();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_i_read();
      test_both_same_cycle();
      test_chain_starve();
      test_abort();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/cache_bus_arb.md
Name: cache_bus_arb

Overview:
- Shares one burst bus engine between the I$ and the D$ line-fill/writeback ports (CacheBusRW/CacheBusAdr/CacheBusAck/BeatCount).
- Registered arbitration with D$ priority, a starvation guard for the I$, and grant lock across a D$ writeback-then-fetch pair.
- Per-beat counting, per-requester BeatCount and single-cycle acks.
- Sits between the two cache instances and the bus interface FSM.

Parameters:
- PA_BITS, 56, physical address width
- LOGBWPL, 3, log2(beats per line); a burst is 2^LOGBWPL beats
- STARVE_LIMIT, 4, consecutive D$ grants tolerated while I$ waits before I$ is forced through (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- ICacheBusRW  input  2  I$ request, [1] read line / [0] write line
- ICacheBusAdr  input  PA_BITS  I$ line address
- ICacheAbort  input  1  I$ FlushStage; withdraws a not-yet-started I$ request
- DCacheBusRW  input  2  D$ request, [1] read line / [0] write line
- DCacheBusAdr  input  PA_BITS  D$ line address
- DCacheAbort  input  1  D$ FlushStage; withdraws a not-yet-started D$ request
- BusBeatDone  input  1  downstream completed one beat this cycle
- BusRW  output  2  request to bus engine, [1] read / [0] write
- BusAdr  output  PA_BITS  line address of the granted requester
- GntD  output  1  1 = D$ owns bus (write-data mux select)
- ICacheBusAck  output  1  one-cycle pulse on last I$ beat
- DCacheBusAck  output  1  one-cycle pulse on last D$ beat
- IBeatCount  output  LOGBWPL  beat index for I$ (0 unless granted)
- DBeatCount  output  LOGBWPL  beat index for D$ (0 unless granted)

Behaviour:
- Reset (async, reset=0):
  - state IDLE; BeatCnt=0, StarveCnt=0, Chain=0.
  - All outputs 0.
- Request validity: ReqX = |XCacheBusRW & ~XCacheAbort. Requesting RW=2'b11 is illegal; an assertion flags it.
- States:
  - IDLE: choose a winner from the request lines in the current cycle, register it, and move to GNT_I or GNT_D next cycle. BusRW/BusAdr are driven from the granted requester's live inputs starting that next cycle, so arbitration latency is 1 cycle.
  - Winner rule, first match:
    1. Chain=1 and ReqD: D wins.
    2. ReqI and StarveCnt==STARVE_LIMIT: I wins.
    3. ReqD: D wins.
    4. ReqI: I wins.
  - GNT_X:
    - BusRW = XCacheBusRW; BusAdr = XCacheBusAdr; GntD = (X==D).
    - Each BusBeatDone increments BeatCnt. XBeatCount = BeatCnt.
    - On BusBeatDone with BeatCnt == 2^LOGBWPL-1: pulse XCacheBusAck that cycle, wrap BeatCnt to 0, return to IDLE.
- Abort:
  - Permitted only while BeatCnt==0 and no BusBeatDone in the current cycle. Effect: next cycle state=IDLE, BusRW=0, no ack.
  - Once any beat has completed, abort is ignored and the burst runs to its ack.
  - A requester dropping RW mid-burst is illegal (assertion).
- StarveCnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while ReqI is high.
  - Clears to 0 on any I grant.
- Chain:
  - Set on DCacheBusAck of a write burst (BusRW[0]=1).
  - Cleared on the next IDLE decision, whether or not D requests.
  - Effect: a D writeback followed by that line's fetch is never split by an I$ burst; this chained grant does not increment StarveCnt.
- Simultaneous events:
  - Ack cycle and a new request from either side: the new request is arbitrated in IDLE the following cycle. There is no back-to-back grant in the ack cycle, so there is one idle bus cycle between bursts.
  - BusBeatDone while IDLE: ignored, assertion.
- Width: BeatCnt is LOGBWPL bits with natural wrap. StarveCnt is $clog2(STARVE_LIMIT+1) bits.

Decomposition:
- Shared package holds a typedef enum logic[1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arbstate_t and the RW encoding constants BUSRW_READ=2'b10, BUSRW_WRITE=2'b01.
- One natural sub-module: arb_beat_counter (LOGBWPL-bit counter with enable, synchronous clear, async active-low reset, last-beat flag).
- The rest is a single FSM plus output muxes in cache_bus_arb.

Test Plan:
- I$ read alone, LOGBWPL=3 (ICacheBusRW=10, Adr=0x80001000): BusRW=10 one cycle later; IBeatCount steps 0..7 with BusBeatDone; ICacheBusAck pulses exactly on beat 7; DBeatCount stays 0.
- I and D request in the same cycle: D granted (GntD=1); I granted after DCacheBusAck plus one IDLE cycle; StarveCnt goes 1 then 0.
- D writeback (01) then immediate read (10) while I requests continuously: D keeps both bursts back-to-back (Chain) and I waits. Then, with STARVE_LIMIT=4 and 4 further D grants, I is forced on the 5th decision.
- DCacheAbort asserted the cycle after grant with no beat done: BusRW=0 next cycle, no DCacheBusAck, I (pending) granted next decision. Abort after beat 2: ignored, and the burst completes to beat 7 with ack.
- reset=0 asynchronously mid-burst at beat 4: all outputs 0 immediately. After release, a new D request restarts at DBeatCount=0.
- Illegal stimulus (RW=11, BusBeatDone in IDLE, RW dropped mid-burst): each fires its assertion, and state is unaffected for the BusBeatDone-in-IDLE case.
